// File: rtl/led_pattern_arbiter_if.sv
// ---------------------------------------------------------------------------
// led_pattern_arbiter_if
//   Bundles the requester side and the LED side of the LED pattern arbiter.
//
//   Signals:
//     req     [NUM_REQ]          level request per requester
//     pattern [NUM_REQ*PAT_LEN]  requester i's pattern at [i*PAT_LEN +: PAT_LEN],
//                                bit 0 is played first
//     grant   [NUM_REQ]          one-hot owner of the current PLAY frame
//     busy                       high while a frame or the inter-frame gap runs
//     done                       one-cycle pulse at the end of each frame
//     led                        registered LED drive, 1 = on
//
//   Handshake: req is a level, not a pulse. A requester holds req high until
//   it sees its grant bit; the arbiter only samples req while idle, so a
//   request that drops before being granted is simply forgotten, and a
//   request held through a whole frame is served again on a later round.
//
//   Modports:
//     slave  - the arbiter (consumes req/pattern, drives grant/busy/done/led)
//     master - the status sources and LED pin side
// ---------------------------------------------------------------------------
interface led_pattern_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int PAT_LEN = 16
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*PAT_LEN-1:0] pattern;
  logic [NUM_REQ-1:0]         grant;
  logic                       busy;
  logic                       done;
  logic                       led;

  modport slave (
    input  req,
    input  pattern,
    output grant,
    output busy,
    output done,
    output led
  );

  modport master (
    output req,
    output pattern,
    input  grant,
    input  busy,
    input  done,
    input  led
  );
endinterface

// File: rtl/led_pattern_arbiter.sv
// ---------------------------------------------------------------------------
// led_pattern_arbiter
//   Shares one board LED between NUM_REQ status sources. Requesters are
//   served round-robin and non-preemptively: the winner's PAT_LEN-bit blink
//   pattern is latched and shown one bit per tick (TICK_DIV clocks), followed
//   by GAP_TICKS ticks of forced-off LED before the next arbitration.
//
//   Ports:
//     clk        system clock, all state on the rising edge
//     reset_n    asynchronous active-low reset
//     bus        led_pattern_arbiter_if.slave (req, pattern -> grant, busy,
//                done, led); every output is a flop
//     state_dbg  current FSM state (0 = IDLE, 1 = PLAY, 2 = GAP)
// ---------------------------------------------------------------------------
module led_pattern_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PAT_LEN   = 16,
  parameter int TICK_DIV  = 6250000,
  parameter int GAP_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  led_pattern_arbiter_if.slave     bus,
  output logic [1:0]               state_dbg
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAT_LEN - 1);
  // Guarded so a GAP_TICKS=0 build never forms a negative constant.
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     last;
  logic [PAT_LEN-1:0]   pat_sr;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [GAP_W-1:0]     gap_cnt;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 led_q;

  // Round-robin pick: the first set req searching last+1, last+2, ...
  // The loop runs from the farthest offset down so the nearest hit wins.
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
  logic [PAT_LEN-1:0]   win_pat;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_pat = bus.pattern[win_idx*PAT_LEN +: PAT_LEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= IDX_W'(NUM_REQ - 1);
      pat_sr   <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      gap_cnt  <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
          grant_q <= '0;
          if (win_found) begin
            state    <= PLAY;
            grant_q  <= NUM_REQ'(1) << win_idx;
            last     <= win_idx;
            // Bit 0 goes straight to the LED; the rest waits in the shifter.
            led_q    <= win_pat[0];
            pat_sr   <= win_pat >> 1;
            tick_cnt <= '0;
            bit_idx  <= '0;
            busy_q   <= 1'b1;
          end
        end

        PLAY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              grant_q <= '0;
              done_q  <= 1'b1;
              led_q   <= 1'b0;
              gap_cnt <= '0;
              if (GAP_TICKS > 0) begin
                state <= GAP;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              led_q   <= pat_sr[0];
              pat_sr  <= pat_sr >> 1;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        GAP: begin
          led_q   <= 1'b0;
          grant_q <= '0;
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (gap_cnt == GAP_LAST) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.led   = led_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_arbiter
//   Directed bench for led_pattern_arbiter with TICK_DIV=4, PAT_LEN=16,
//   NUM_REQ=4. u0 is built with GAP_TICKS=2, u1 with GAP_TICKS=0.
//   Inputs are driven 1 time unit after each rising edge; outputs are
//   sampled at the same point.
// ---------------------------------------------------------------------------
module tb_led_pattern_arbiter;

  localparam int NR = 4;
  localparam int PL = 16;
  localparam int TD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  led_pattern_arbiter_if #(.NUM_REQ(NR), .PAT_LEN(PL)) bus0 ();
  led_pattern_arbiter_if #(.NUM_REQ(NR), .PAT_LEN(PL)) bus1 ();
  logic [1:0] st0;
  logic [1:0] st1;

  led_pattern_arbiter #(.NUM_REQ(NR), .PAT_LEN(PL), .TICK_DIV(TD), .GAP_TICKS(2)) u0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus0),
    .state_dbg (st0)
  );

  led_pattern_arbiter #(.NUM_REQ(NR), .PAT_LEN(PL), .TICK_DIV(TD), .GAP_TICKS(0)) u1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus1),
    .state_dbg (st1)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_pat0(input int i, input logic [PL-1:0] p);
    bus0.pattern[i*PL +: PL] = p;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Called right after the grant edge: checks the whole frame, ends at the
  // done edge.
  task automatic play_check0(input logic [PL-1:0] pat, input logic [NR-1:0] g);
    for (int j = 0; j < PL*TD; j++) begin
      chk("play_led", 32'(bus0.led), 32'(pat[j/TD]));
      chk("play_grant", 32'(bus0.grant), 32'(g));
      chk("play_busy", 32'(bus0.busy), 32'd1);
      chk("play_done", 32'(bus0.done), 32'd0);
      step();
    end
    chk("end_done", 32'(bus0.done), 32'd1);
    chk("end_grant", 32'(bus0.grant), 32'd0);
    chk("end_led", 32'(bus0.led), 32'd0);
    chk("end_busy", 32'(bus0.busy), 32'd1);
  endtask

  // From the done edge, count cycles until the next grant appears.
  task automatic next_grant0(input int exp_n, input logic [NR-1:0] exp_g);
    int n;
    n = 0;
    while (bus0.grant == '0 && n < 200) begin
      chk("gap_led", 32'(bus0.led), 32'd0);
      step();
      n++;
    end
    chk("grant_spacing", 32'(n), 32'(exp_n));
    chk("next_grant", 32'(bus0.grant), 32'(exp_g));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PL-1:0] p0, p1, p2, p3, pm;
    int n;
    reset_n      = 1'b0;
    bus0.req     = '0;
    bus0.pattern = '0;
    bus1.req     = '0;
    bus1.pattern = '0;
    step();
    step();
    chk("rst_outputs0", {28'd0, bus0.led, bus0.busy, bus0.done, 1'b0} | 32'(bus0.grant), 32'd0);
    chk("rst_state0", 32'(st0), 32'd0);
    reset_n = 1'b1;

    // No requests: everything stays quiet.
    for (int i = 0; i < 200; i++) begin
      chk("idle_u0", {bus0.led, bus0.busy, bus0.done, 25'd0, bus0.grant}, 32'd0);
      chk("idle_u1", {bus1.led, bus1.busy, bus1.done, 25'd0, bus1.grant}, 32'd0);
      step();
    end

    // Single frame from req0, then gap and back to idle.
    pm = 16'hA5F0;
    set_pat0(0, pm);
    bus0.req = 4'b0001;
    step();
    bus0.req = 4'b0000;
    play_check0(pm, 4'b0001);
    for (int g = 0; g < 2*TD; g++) begin
      chk("gap_led", 32'(bus0.led), 32'd0);
      chk("gap_busy", 32'(bus0.busy), 32'd1);
      chk("gap_grant", 32'(bus0.grant), 32'd0);
      chk("gap_done", 32'(bus0.done), (g == 0) ? 32'd1 : 32'd0);
      chk("gap_state", 32'(st0), 32'd2);
      step();
    end
    chk("post_gap_busy", 32'(bus0.busy), 32'd0);
    chk("post_gap_state", 32'(st0), 32'd0);

    // Round-robin with all requests held; p2 is the all-zero frame.
    do_reset();
    p0 = 16'h1234; p1 = 16'hFFFF; p2 = 16'h0000; p3 = 16'h8001;
    set_pat0(0, p0); set_pat0(1, p1); set_pat0(2, p2); set_pat0(3, p3);
    bus0.req = 4'b1111;
    step();
    play_check0(p0, 4'b0001);
    next_grant0(2*TD + 1, 4'b0010);
    play_check0(p1, 4'b0010);
    next_grant0(2*TD + 1, 4'b0100);
    play_check0(p2, 4'b0100);
    next_grant0(2*TD + 1, 4'b1000);
    play_check0(p3, 4'b1000);
    next_grant0(2*TD + 1, 4'b0001);

    // Owner drops req mid-frame; next arbitration must pick req1.
    pm = 16'hC3A5;
    set_pat0(1, pm);
    bus0.req = 4'b0010;
    play_check0(p0, 4'b0001);
    next_grant0(2*TD + 1, 4'b0010);

    // Mid-frame: drop req1, raise req0, change pattern1 -> frame unaffected.
    for (int j = 0; j < PL*TD; j++) begin
      if (j == 20) begin
        bus0.req = 4'b0001;
        set_pat0(1, 16'h3C5A);
      end
      chk("mid_led", 32'(bus0.led), 32'(pm[j/TD]));
      chk("mid_grant", 32'(bus0.grant), 32'h2);
      step();
    end
    chk("mid_done", 32'(bus0.done), 32'd1);
    next_grant0(2*TD + 1, 4'b0001);

    // Reset at cycle 30 of a PLAY frame.
    for (int j = 0; j < 30; j++) step();
    chk("pre_rst_grant", 32'(bus0.grant), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(bus0.led), 32'd0);
    chk("async_rst_grant", 32'(bus0.grant), 32'd0);
    chk("async_rst_busy", 32'(bus0.busy), 32'd0);
    chk("async_rst_done", 32'(bus0.done), 32'd0);
    step();
    chk("rst_hold_done", 32'(bus0.done), 32'd0);
    chk("rst_hold_state", 32'(st0), 32'd0);
    bus0.req = 4'b1010;
    reset_n = 1'b1;
    step();
    chk("post_rst_grant", 32'(bus0.grant), 32'h2);
    chk("post_rst_led", 32'(bus0.led), 32'd0);
    chk("post_rst_busy", 32'(bus0.busy), 32'd1);

    // GAP_TICKS=0 build: back-to-back frames one IDLE cycle apart.
    bus1.pattern[2*PL +: PL] = 16'h00FF;
    bus1.req = 4'b0100;
    step();
    chk("g0_grant", 32'(bus1.grant), 32'h4);
    chk("g0_led0", 32'(bus1.led), 32'd1);
    n = 0;
    while (bus1.done == 1'b0 && n < 200) begin
      chk("g0_play_grant", 32'(bus1.grant), 32'h4);
      step();
      n++;
    end
    chk("g0_frame_len", 32'(n), 32'(PL*TD));
    chk("g0_end_grant", 32'(bus1.grant), 32'd0);
    chk("g0_end_busy", 32'(bus1.busy), 32'd0);
    chk("g0_end_state", 32'(st1), 32'd0);
    while (bus1.grant == '0 && n < 300) begin
      step();
      n++;
    end
    chk("g0_regrant_spacing", 32'(n), 32'(PL*TD + 1));
    chk("g0_regrant", 32'(bus1.grant), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case anything wedges the sequence above.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pattern_arbiter.md
Name: led_pattern_arbiter

Overview:
- Shares the single board LED between NUM_REQ requesters (e.g. heartbeat, CPU halt, trap/error indicators).
- Round-robin, non-preemptive arbitration. The granted requester's PAT_LEN-bit blink pattern is latched and played out serially, one bit per tick.
- Sits between status sources in the SoC top and the board `led` pin, replacing a free-running blinker.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- PAT_LEN, 16: pattern length in bits, one bit shown per tick.
- TICK_DIV, 6250000: clk cycles per tick (>=2). At 100 MHz this gives a 16 Hz bit rate.
- GAP_TICKS, 2: ticks of forced LED-off between frames (0 allowed).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request per requester.
- pattern  input  NUM_REQ*PAT_LEN  requester i's pattern in bits [i*PAT_LEN +: PAT_LEN]; bit 0 plays first.
- grant  output  NUM_REQ  one-hot, high for the whole PLAY frame of the owner.
- busy  output  1  high in PLAY or GAP.
- done  output  1  one-cycle pulse at end of each frame.
- led  output  1  registered LED drive, 1 = on.

Behaviour:
- One clock, asynchronous active-low reset (reset_n). Reset values:
  - state=IDLE, grant=0, busy=0, done=0, led=0.
  - tick counter=0, bit index=0.
  - RR pointer last=NUM_REQ-1, so req[0] wins first.
- All outputs are registered; no combinational path from inputs to outputs.
- States are IDLE, PLAY, GAP.

IDLE:
- led=0, busy=0.
- On each edge where req!=0, pick the first set bit searching last+1, last+2, ... modulo NUM_REQ.
- Same edge (call it edge k): state=PLAY, grant[w]=1, last=w, latch pattern slice w, bit index=0, tick counter=0, led=pattern_w[0], busy=1.
- Latency: req sampled at edge k gives grant and led valid after edge k. Minimum one cycle in IDLE between frames.

PLAY:
- Tick counter counts 0..TICK_DIV-1, then wraps.
- Bit i is shown on led for exactly TICK_DIV cycles, over [k+i*TICK_DIV, k+(i+1)*TICK_DIV).
- At edge k+PAT_LEN*TICK_DIV: grant=0, done=1 for one cycle, led=0.
  - state=GAP if GAP_TICKS>0, else IDLE.
- Non-preemptive:
  - A lower-index or newly asserted req does not interrupt the frame.
  - Owner deasserting req mid-frame does not abort the frame.
  - Pattern input changes mid-frame are ignored, because the pattern is latched.

GAP:
- led=0, busy=1, grant=0.
- Lasts GAP_TICKS*TICK_DIV cycles, then state=IDLE (busy=0). Requests are not arbitrated during GAP.

Boundaries:
- All req low forever: stay in IDLE, led=0.
- A single requester held continuously gets back-to-back frames separated by the GAP plus one IDLE cycle.
- Pattern all zeros: full-length frame with led=0; done still pulses.
- Round-robin fairness: with all req high, grants rotate 0,1,2,3,0,...
- Pointer update happens only at grant.
- reset_n asserted mid-PLAY or mid-GAP: immediate return to reset values, with no done pulse. After release, the first arbitration again favours req[0].
- grant is always one-hot or zero. done never coincides with grant!=0.

Test Plan (NUM_REQ=4, PAT_LEN=16, TICK_DIV=4, GAP_TICKS=2):
- Reset with req=0, run 200 cycles -> led=0, grant=0, busy=0, done=0 throughout.
- req=4'b0001, pattern0=16'hA5F0 from edge 0 -> grant=4'b0001 after edge 0. led follows bits 0..15 of 16'hA5F0 (0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1), 4 cycles each. done pulses 64 cycles after grant, then 8 GAP cycles with led=0.
- req=4'b1111 held, distinct patterns -> grants in order 0,1,2,3,0. Each frame is 64 cycles, with 73 cycles from one grant to the next.
- Mid-frame: grant to req1, then at cycle 20 drop req1, raise req0 and change pattern1 -> frame continues with the latched pattern1 to 64 cycles. Next grant goes to req0 after GAP+IDLE.
- Assert reset_n=0 at cycle 30 of a PLAY frame -> led, grant and busy go to 0 asynchronously, with no done. After release with req=4'b1010, the first grant is req1.
- GAP_TICKS=0 build with req=4'b0100 held -> done, then one IDLE cycle, then grant=4'b0100 again 65 cycles after the previous grant.
